// File: rtl/project_pkg.sv
// Shared types and default parameters for the AXI-Stream frame arbiter.
package project_pkg;
  localparam int N_IN_DEF    = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    ABORT = 2'd2,
    DROP  = 2'd3
  } arb_state_t;

  // Index width for an n-entry one-hot vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module axis_rr_pick
  import project_pkg::*;
#(
  parameter int N  = N_IN_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   k;
    logic found;
    k     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// N-input AXI-Stream frame arbiter: round-robin per whole frame, with a
// mid-frame idle watchdog that emits a tuser-marked abort beat and drops the rest.
module axis_frame_arbiter
  import project_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN*DATA_W-1:0]   s_tdata,
  input  logic [N_IN-1:0]          s_tvalid,
  input  logic [N_IN-1:0]          s_tlast,
  output logic [N_IN-1:0]          s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  output logic                     m_tuser,
  input  logic                     m_tready,
  output logic [N_IN-1:0]          grant,
  output logic [15:0]              abort_cnt,
  output logic [1:0]               state_dbg
);

  localparam int         IW      = idx_w(N_IN);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  // Handshake: a beat moves on a rising edge where tvalid and tready are both 1;
  // a source holds tdata/tlast stable while tvalid=1 and tready=0, and tvalid
  // never depends on tready.

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [N_IN-1:0]     grant_q, grant_d;
  logic [7:0]          wd_q, wd_d;
  logic [15:0]         abort_q, abort_d;

  logic [N_IN-1:0]     pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       pick_next;
  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;

  axis_rr_pick #(
    .N  (N_IN),
    .IW (IW)
  ) u_pick (
    .req (s_tvalid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign pick_next = (pick_idx == IW'(N_IN - 1)) ? '0 : pick_idx + 1'b1;
  assign g_valid   = s_tvalid[gidx_q];
  assign g_last    = s_tlast[gidx_q];
  assign g_data    = s_tdata[int'(gidx_q)*DATA_W +: DATA_W];

  assign grant     = grant_q;
  assign abort_cnt = abort_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      wd_q    <= '0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wd_q    <= wd_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    wd_d     = wd_q;
    abort_d  = abort_q;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;
    s_tready = '0;

    case (state_q)
      IDLE: begin
        if (|s_tvalid) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          ptr_d   = pick_next;
          wd_d    = '0;
          state_d = PASS;
        end
      end

      PASS: begin
        m_tdata          = g_data;
        m_tvalid         = g_valid;
        m_tlast          = g_last;
        s_tready[gidx_q] = m_tready;
        // Only source starvation feeds the watchdog; back-pressure clears it.
        if (g_valid) begin
          wd_d = '0;
          if (m_tready && g_last) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (wd_q == TO_LAST) begin
          state_d = ABORT;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end

      ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
        if (m_tready) begin
          if (abort_q != 16'hFFFF) abort_d = abort_q + 16'd1;
          state_d = DROP;
        end
      end

      DROP: begin
        s_tready[gidx_q] = 1'b1;
        if (g_valid && g_last) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: per-cycle vector table plus
// hand-written abort, stall and mid-frame reset sequences.
module tb_axis_frame_arbiter;
  import project_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int W  = DW + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   s_tdata;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tuser;
  logic              m_tready;
  logic [N-1:0]      grant;
  logic [15:0]       abort_cnt;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int bad;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        chk;
    logic [3:0]  tvalid;
    logic [3:0]  tlast;
    logic [31:0] tdata;
    logic        mready;
    logic [18:0] ex;
  } vec_t;
  vec_t vecs[$];

  axis_frame_arbiter #(
    .N_IN    (N),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser),
    .m_tready  (m_tready),
    .grant     (grant),
    .abort_cnt (abort_cnt),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] obs();
    return {grant, m_tvalid, m_tlast, m_tuser, m_tdata, s_tready};
  endfunction

  function automatic logic [18:0] e(input logic [3:0] g, input logic mv, input logic ml,
                                    input logic mu, input logic [7:0] md, input logic [3:0] tr);
    return {g, mv, ml, mu, md, tr};
  endfunction

  // driver tasks
  task automatic drive(input logic [3:0] tv, input logic [3:0] tl, input logic [31:0] td,
                       input logic mr);
    s_tvalid = tv;
    s_tlast  = tl;
    s_tdata  = td;
    m_tready = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic c, input logic [3:0] tv, input logic [3:0] tl,
                     input logic [31:0] td, input logic mr, input logic [18:0] ex);
    vec_t v;
    v.rst = r; v.chk = c; v.tvalid = tv; v.tlast = tl;
    v.tdata = td; v.mready = mr; v.ex = ex;
    vecs.push_back(v);
  endtask

  // scoreboard: every accepted master beat must match the expected queue head
  always @(negedge clk) begin
    logic [W-1:0] x;
    if (!rst && m_tvalid && m_tready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got %0h expected none", {m_tuser, m_tlast, m_tdata});
      end else begin
        x = exp_q.pop_front();
        if ({m_tuser, m_tlast, m_tdata} !== x) begin
          n_errors++;
          $display("FAIL sb_beat: got %0h expected %0h", {m_tuser, m_tlast, m_tdata}, x);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("reset_obs", 32'(obs()), 32'h0);
    chk("reset_abort_cnt", 32'(abort_cnt), 32'h0);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));
    step();

    // inputs 0 and 2 start 3-beat frames together
    add(0, 1, 4'b0101, 4'b0000, 32'h00200010, 1, e(4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    add(0, 1, 4'b0101, 4'b0000, 32'h00200010, 1, e(4'b0001, 1, 0, 0, 8'h10, 4'b0001));
    add(0, 1, 4'b0101, 4'b0000, 32'h00200011, 1, e(4'b0001, 1, 0, 0, 8'h11, 4'b0001));
    add(0, 1, 4'b0101, 4'b0001, 32'h00200012, 1, e(4'b0001, 1, 1, 0, 8'h12, 4'b0001));
    add(0, 1, 4'b0100, 4'b0000, 32'h00200000, 1, e(4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    add(0, 1, 4'b0100, 4'b0000, 32'h00200000, 1, e(4'b0100, 1, 0, 0, 8'h20, 4'b0100));
    add(0, 1, 4'b0100, 4'b0000, 32'h00210000, 1, e(4'b0100, 1, 0, 0, 8'h21, 4'b0100));
    add(0, 1, 4'b0100, 4'b0100, 32'h00220000, 1, e(4'b0100, 1, 1, 0, 8'h22, 4'b0100));
    add(0, 1, 4'b0000, 4'b0000, 32'h00000000, 1, e(4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    add(1, 0, 4'b0000, 4'b0000, 32'h00000000, 1, e(4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    // all four inputs sending back-to-back single-beat frames
    add(0, 1, 4'b1111, 4'b1111, 32'h33323130, 1, e(4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    add(0, 1, 4'b1111, 4'b1111, 32'h33323130, 1, e(4'b0001, 1, 1, 0, 8'h30, 4'b0001));
    add(0, 1, 4'b1111, 4'b1111, 32'h33323130, 1, e(4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    add(0, 1, 4'b1111, 4'b1111, 32'h33323130, 1, e(4'b0010, 1, 1, 0, 8'h31, 4'b0010));
    add(0, 1, 4'b1111, 4'b1111, 32'h33323130, 1, e(4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    add(0, 1, 4'b1111, 4'b1111, 32'h33323130, 1, e(4'b0100, 1, 1, 0, 8'h32, 4'b0100));
    add(0, 1, 4'b1111, 4'b1111, 32'h33323130, 1, e(4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    add(0, 1, 4'b1111, 4'b1111, 32'h33323130, 1, e(4'b1000, 1, 1, 0, 8'h33, 4'b1000));
    add(0, 1, 4'b1111, 4'b1111, 32'h33323130, 1, e(4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    add(0, 1, 4'b1111, 4'b1111, 32'h33323130, 1, e(4'b0001, 1, 1, 0, 8'h30, 4'b0001));
    add(0, 1, 4'b0000, 4'b0000, 32'h00000000, 1, e(4'b0000, 0, 0, 0, 8'h00, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].tvalid, vecs[i].tlast, vecs[i].tdata, vecs[i].mready);
      if (vecs[i].chk && !vecs[i].rst && vecs[i].mready && vecs[i].ex[14])
        exp_q.push_back({vecs[i].ex[12], vecs[i].ex[13], vecs[i].ex[11:4]});
      @(negedge clk);
      if (vecs[i].chk) chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].ex));
      step();
    end
    rst = 1'b0;

    // watchdog abort on input 1 (pointer now at 1)
    drive(4'b0010, 4'b0000, 32'h0000A500, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    @(negedge clk);
    chk("to_idle", 32'(obs()), 32'h0);
    step();
    @(negedge clk);
    chk("to_first_beat", 32'(obs()), 32'(e(4'b0010, 1, 0, 0, 8'hA5, 4'b0010)));
    step();
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      if (i == TO) begin
        chk("to_last_idle_state", 32'(state_dbg), 32'(PASS));
        chk("to_last_idle_obs", 32'(obs()), 32'(e(4'b0010, 0, 0, 0, 8'h00, 4'b0010)));
      end
      step();
    end
    drive(4'b0010, 4'b0000, 32'h0000B100, 1'b1);
    exp_q.push_back({1'b1, 1'b1, 8'h00});
    @(negedge clk);
    chk("to_abort_state", 32'(state_dbg), 32'(ABORT));
    chk("to_abort_beat", 32'(obs()), 32'(e(4'b0010, 1, 1, 1, 8'h00, 4'b0000)));
    step();
    @(negedge clk);
    chk("to_drop_obs", 32'(obs()), 32'(e(4'b0010, 0, 0, 0, 8'h00, 4'b0010)));
    chk("to_abort_cnt", 32'(abort_cnt), 32'h1);
    step();
    drive(4'b0010, 4'b0010, 32'h0000B200, 1'b1);
    @(negedge clk);
    chk("to_drop_state", 32'(state_dbg), 32'(DROP));
    step();
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    chk("to_end_state", 32'(state_dbg), 32'(IDLE));
    chk("to_end_obs", 32'(obs()), 32'h0);
    step();

    // 40-cycle master stall on input 3 with the source valid
    drive(4'b1000, 4'b0000, 32'h40000000, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h40});
    step();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (obs() !== e(4'b1000, 1, 0, 0, 8'h40, 4'b0000) || state_dbg !== 2'(PASS)) bad++;
      step();
    end
    chk("stall_stable", 32'(bad), 32'h0);
    drive(4'b1000, 4'b0000, 32'h40000000, 1'b1);
    @(negedge clk);
    chk("stall_release", 32'(obs()), 32'(e(4'b1000, 1, 0, 0, 8'h40, 4'b1000)));
    step();
    drive(4'b1000, 4'b1000, 32'h41000000, 1'b1);
    exp_q.push_back({1'b0, 1'b1, 8'h41});
    @(negedge clk);
    chk("stall_last", 32'(obs()), 32'(e(4'b1000, 1, 1, 0, 8'h41, 4'b1000)));
    step();
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    chk("stall_abort_cnt", 32'(abort_cnt), 32'h1);
    chk("stall_end_state", 32'(state_dbg), 32'(IDLE));
    step();

    // reset during the 2nd beat of a 4-beat frame on input 2
    drive(4'b0100, 4'b0000, 32'h00500000, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 8'h50});
    step();
    @(negedge clk);
    chk("rst_first_beat", 32'(obs()), 32'(e(4'b0100, 1, 0, 0, 8'h50, 4'b0100)));
    step();
    drive(4'b0100, 4'b0000, 32'h00510000, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(4'b1010, 4'b0010, 32'h63006100, 1'b1);
    exp_q.push_back({1'b0, 1'b1, 8'h61});
    @(negedge clk);
    chk("rst_obs", 32'(obs()), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_abort_cnt", 32'(abort_cnt), 32'h0);
    step();
    @(negedge clk);
    chk("rst_ptr_grant", 32'(obs()), 32'(e(4'b0010, 1, 1, 0, 8'h61, 4'b0010)));
    step();
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    chk("rst_end_state", 32'(state_dbg), 32'(IDLE));
    step();

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
